// File: rtl/sync_fifo_pkg.sv
// rtl/sync_fifo_pkg.sv - shared constants and parameter checks for sync_fifo_flags
package sync_fifo_pkg;

   localparam int MODE_STD  = 0;
   localparam int MODE_FWFT = 1;

   function automatic int addr_width(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

   function automatic bit params_ok(input int data_width, input int depth, input int fwft,
                                    input int afull, input int aempty);
      return (data_width >= 1) && (depth >= 4) && ((depth & (depth - 1)) == 0) &&
             ((fwft == MODE_STD) || (fwft == MODE_FWFT)) &&
             (afull >= 1) && (afull <= depth) && (aempty >= 0) && (aempty <= depth - 1);
   endfunction

endpackage

// File: rtl/fifo_ram_sdp.sv
// rtl/fifo_ram_sdp.sv - simple dual-port register array with synchronous read port
module fifo_ram_sdp
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int DEPTH      = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        i_we,
   input  logic [addr_width(DEPTH)-1:0] i_waddr,
   input  logic [DATA_WIDTH-1:0]       i_wdata,
   input  logic                        i_re,
   input  logic [addr_width(DEPTH)-1:0] i_raddr,
   output logic [DATA_WIDTH-1:0]       o_rdata
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [DATA_WIDTH-1:0] r_rdata;

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   // Same-address forwarding lets a write into an empty FIFO land in the read register at once.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/sync_fifo_flags.sv
// rtl/sync_fifo_flags.sv - single-clock FIFO with standard/FWFT read, count, level and error flags
module sync_fifo_flags
   import sync_fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int DEPTH         = 16,
   parameter int FWFT          = 0,
   parameter int AFULL_THRESH  = DEPTH - 2,
   parameter int AEMPTY_THRESH = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      wr_en,
   input  logic [DATA_WIDTH-1:0]     din,
   input  logic                      rd_en,
   input  logic                      clr_err,
   output logic [DATA_WIDTH-1:0]     dout,
   output logic                      full,
   output logic                      empty,
   output logic                      almost_full,
   output logic                      almost_empty,
   output logic [addr_width(DEPTH):0] count,
   output logic                      overflow,
   output logic                      underflow
);

   localparam int ADDR_WIDTH = addr_width(DEPTH);
   localparam int CNT_WIDTH  = ADDR_WIDTH + 1;

   if (!params_ok(DATA_WIDTH, DEPTH, FWFT, AFULL_THRESH, AEMPTY_THRESH)) begin : g_param_check
      $error("sync_fifo_flags: illegal parameter combination");
   end

   logic [ADDR_WIDTH:0]   r_wr_ptr;
   logic [ADDR_WIDTH:0]   r_rd_ptr;
   logic [CNT_WIDTH-1:0]  r_count;
   logic                  r_valid;
   logic                  r_overflow;
   logic                  r_underflow;

   logic                  w_full;
   logic                  w_empty;
   logic                  w_mem_empty;
   logic                  w_wr_acc;
   logic                  w_rd_acc;
   logic                  w_load;

   assign w_full      = (r_count == CNT_WIDTH'(DEPTH));
   assign w_mem_empty = (r_wr_ptr == r_rd_ptr);
   assign w_empty     = (FWFT == MODE_FWFT) ? ~r_valid : (r_count == '0);
   assign w_wr_acc    = wr_en & ~w_full;
   assign w_rd_acc    = rd_en & ~w_empty;

   // FWFT keeps the head word in the output register: refill it whenever it is free or being popped.
   assign w_load = (FWFT == MODE_FWFT) ? ((~w_mem_empty | w_wr_acc) & (~r_valid | w_rd_acc))
                                       : w_rd_acc;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_valid     <= 1'b0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + (ADDR_WIDTH+1)'(1);
         end
         if (w_load) begin
            r_rd_ptr <= r_rd_ptr + (ADDR_WIDTH+1)'(1);
         end
         r_count <= r_count + CNT_WIDTH'(w_wr_acc) - CNT_WIDTH'(w_rd_acc);
         if (w_load) begin
            r_valid <= 1'b1;
         end else if (w_rd_acc) begin
            r_valid <= 1'b0;
         end
         r_overflow  <= (wr_en & w_full) | (r_overflow & ~clr_err);
         r_underflow <= (rd_en & w_empty) | (r_underflow & ~clr_err);
      end
   end

   fifo_ram_sdp #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_ram (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_wr_acc & ~rst),
      .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
      .i_wdata (din),
      .i_re    (w_load),
      .i_raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
      .o_rdata (dout)
   );

   assign full         = w_full;
   assign empty        = w_empty;
   assign count        = r_count;
   assign almost_full  = (r_count >= CNT_WIDTH'(AFULL_THRESH));
   assign almost_empty = (r_count <= CNT_WIDTH'(AEMPTY_THRESH));
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// tb/tb_sync_fifo_flags.sv - self-checking bench for sync_fifo_flags in standard and FWFT modes
module tb_sync_fifo_flags;

   localparam int DW    = 8;
   localparam int DEPTH = 16;
   localparam int AF    = DEPTH - 2;
   localparam int AE    = 2;

   logic          clk = 1'b0;
   logic          rst, wr_en, rd_en, clr_err;
   logic [DW-1:0] din;

   logic [DW-1:0] s_dout, f_dout;
   logic          s_full, s_empty, s_af, s_ae, s_ov, s_un;
   logic          f_full, f_empty, f_af, f_ae, f_ov, f_un;
   logic [4:0]    s_count, f_count;

   always #5 clk = ~clk;

   sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(0)) dut_s (
      .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .clr_err(clr_err),
      .dout(s_dout), .full(s_full), .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
      .count(s_count), .overflow(s_ov), .underflow(s_un));

   sync_fifo_flags #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1)) dut_f (
      .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .clr_err(clr_err),
      .dout(f_dout), .full(f_full), .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
      .count(f_count), .overflow(f_ov), .underflow(f_un));

   // Reference: a queue of held words; both read modes share contents and accept rules.
   logic [DW-1:0] q[$];
   logic [DW-1:0] m_last;
   logic          m_ov, m_un;
   int            total = 0;
   int            bad   = 0;

   typedef struct {
      logic          w;
      logic [DW-1:0] d;
      logic          r;
      logic          c;
      logic          rs;
      int            cnt;
      logic          emp;
      logic          ful;
      logic          ov;
      logic          un;
      logic [DW-1:0] dout;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step(input logic w, input logic [DW-1:0] d, input logic r,
                             input logic c, input logic rs);
      bit was_full, was_empty;
      if (rs) begin
         q.delete();
         m_last = '0;
         m_ov   = 1'b0;
         m_un   = 1'b0;
      end else begin
         was_full  = (q.size() == DEPTH);
         was_empty = (q.size() == 0);
         if (r && !was_empty) m_last = q.pop_front();
         if (w && !was_full) q.push_back(d);
         m_ov = (w && was_full) || (m_ov && !c);
         m_un = (r && was_empty) || (m_un && !c);
      end
   endtask

   task automatic check_model();
      int n;
      n = q.size();
      chk("s_count", 32'(s_count), n);
      chk("s_full", 32'(s_full), 32'(n == DEPTH));
      chk("s_empty", 32'(s_empty), 32'(n == 0));
      chk("s_afull", 32'(s_af), 32'(n >= AF));
      chk("s_aempty", 32'(s_ae), 32'(n <= AE));
      chk("s_ovf", 32'(s_ov), 32'(m_ov));
      chk("s_unf", 32'(s_un), 32'(m_un));
      chk("s_dout", 32'(s_dout), 32'(m_last));
      chk("f_count", 32'(f_count), n);
      chk("f_full", 32'(f_full), 32'(n == DEPTH));
      chk("f_empty", 32'(f_empty), 32'(n == 0));
      chk("f_afull", 32'(f_af), 32'(n >= AF));
      chk("f_aempty", 32'(f_ae), 32'(n <= AE));
      chk("f_ovf", 32'(f_ov), 32'(m_ov));
      chk("f_unf", 32'(f_un), 32'(m_un));
      if (n > 0) chk("f_dout_head", 32'(f_dout), 32'(q[0]));
   endtask

   task automatic cyc(input logic w, input logic [DW-1:0] d, input logic r,
                      input logic c, input logic rs);
      wr_en = w; din = d; rd_en = r; clr_err = c; rst = rs;
      @(posedge clk);
      model_step(w, d, r, c, rs);
      #1;
      check_model();
   endtask

   task automatic wr(input logic [DW-1:0] d); cyc(1'b1, d, 1'b0, 1'b0, 1'b0); endtask
   task automatic rd();                        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0); endtask
   task automatic idle();                      cyc(1'b0, '0, 1'b0, 1'b0, 1'b0); endtask
   task automatic reset();                     cyc(1'b0, '0, 1'b0, 1'b0, 1'b1); endtask

   initial begin
      //            w     d      r     c     rs    cnt emp   ful   ov    un    dout
      tbl[0] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
      tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00};
      tbl[2] = '{1'b1, 8'h31, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00};
      tbl[3] = '{1'b1, 8'h32, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h31};
      tbl[4] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h31};
      tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h32};
      tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h32};
      tbl[7] = '{1'b1, 8'h40, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h32};
      tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h32};
      tbl[9] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};

      q.delete(); m_last = '0; m_ov = 1'b0; m_un = 1'b0;
      rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = '0;
      reset();
      reset();

      // Idle after reset
      for (int i = 0; i < 5; i++) idle();
      chk("idle_empty", 32'(s_empty), 1);
      chk("idle_aempty", 32'(s_ae), 1);
      chk("idle_count", 32'(s_count), 0);
      chk("idle_dout", 32'(s_dout), 0);
      chk("idle_err", 32'({s_ov, s_un, f_ov, f_un}), 0);

      // Directed vector table
      for (int i = 0; i < 10; i++) begin
         cyc(tbl[i].w, tbl[i].d, tbl[i].r, tbl[i].c, tbl[i].rs);
         chk($sformatf("tbl%0d_count", i), 32'(s_count), tbl[i].cnt);
         chk($sformatf("tbl%0d_empty", i), 32'(s_empty), 32'(tbl[i].emp));
         chk($sformatf("tbl%0d_full", i), 32'(s_full), 32'(tbl[i].ful));
         chk($sformatf("tbl%0d_ovf", i), 32'(s_ov), 32'(tbl[i].ov));
         chk($sformatf("tbl%0d_unf", i), 32'(s_un), 32'(tbl[i].un));
         chk($sformatf("tbl%0d_dout", i), 32'(s_dout), 32'(tbl[i].dout));
      end

      // Fill, overfill, drain
      for (int i = 0; i < DEPTH; i++) begin
         wr(8'(i));
         chk("fill_afull", 32'(s_af), 32'(i + 1 >= 14));
      end
      chk("fill_full", 32'(s_full), 1);
      wr(8'hAA);
      chk("ovf_count", 32'(s_count), 16);
      chk("ovf_flag", 32'(s_ov), 1);
      for (int i = 0; i < DEPTH; i++) begin
         rd();
         chk("drain_dout", 32'(s_dout), i);
      end
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);

      // Wrap-around with steady occupancy of 3
      wr(8'h80); wr(8'h81); wr(8'h82);
      for (int i = 0; i < 40; i++) begin
         cyc(1'b1, 8'(8'h83 + i), 1'b1, 1'b0, 1'b0);
         chk("wrap_count", 32'(s_count), 3);
         chk("wrap_dout", 32'(s_dout), 32'(8'(8'h80 + i)));
      end
      chk("wrap_err", 32'({s_ov, s_un}), 0);

      // Simultaneous ops at full and empty
      while (q.size() < DEPTH) wr(8'($urandom));
      cyc(1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
      chk("simfull_count", 32'(s_count), 15);
      chk("simfull_ovf", 32'(s_ov), 1);
      while (q.size() > 0) rd();
      cyc(1'b1, 8'hC4, 1'b1, 1'b0, 1'b0);
      chk("simempty_count", 32'(s_count), 1);
      chk("simempty_unf", 32'(s_un), 1);
      cyc(1'b0, '0, 1'b0, 1'b1, 1'b0);
      chk("clr_flags", 32'({s_ov, s_un, f_ov, f_un}), 0);

      // FWFT fall-through and back-to-back pops
      reset();
      wr(8'h5A);
      chk("fwft_empty", 32'(f_empty), 0);
      chk("fwft_dout", 32'(f_dout), 32'h5A);
      wr(8'h11); wr(8'h22);
      chk("fwft_head0", 32'(f_dout), 32'h5A);
      rd();
      chk("fwft_head1", 32'(f_dout), 32'h11);
      rd();
      chk("fwft_head2", 32'(f_dout), 32'h22);
      rd();
      chk("fwft_drained", 32'(f_empty), 1);
      chk("fwft_unf", 32'(f_un), 0);

      // Reset in the middle of traffic
      for (int i = 0; i < 7; i++) wr(8'(8'h60 + i));
      cyc(1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
      chk("mrst_count", 32'(s_count), 0);
      chk("mrst_empty", 32'({s_empty, f_empty}), 32'b11);
      wr(8'h77);
      chk("mrst_fwft", 32'(f_dout), 32'h77);
      rd();
      chk("mrst_std", 32'(s_dout), 32'h77);

      // Randomized traffic in phases biased toward full, balanced and empty
      for (int i = 0; i < 600; i++) begin
         int wp;
         logic w, r, c, rs;
         wp = (i / 50) % 3 == 0 ? 80 : ((i / 50) % 3 == 1 ? 50 : 20);
         w  = ($urandom_range(99) < wp);
         r  = ($urandom_range(99) < 100 - wp);
         c  = ($urandom_range(31) == 0);
         rs = ($urandom_range(249) == 0);
         cyc(w, 8'($urandom), r, c, rs);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
